trng_collector: RTL
===================

// Module: trng_collector
// PURPOSE
//  Receive end of the raw entropy path. Takes the single XOR'd ring-oscillator bit from the
//  sampler, synchronises it into the clk domain and optionally debiases it (von Neumann).
//  Packs accepted bits into WORD_W-bit words for the system side over a valid/ready handshake.
//  Runs a repetition-count health test on raw samples; on failure it latches a sticky fault
//  and withholds all output.
// PARAMETERS
//  WORD_W     32  width of an output word, in accepted bits
//  VN_EN      1   1: von Neumann debiasing on; 0: every synchronised sample is accepted
//  REP_LIMIT  32  run of identical raw samples that triggers health_fail (range 2..255)
// PORTS
//  clk          in   1       system clock; also the sampling strobe
//  rst_n        in   1       asynchronous, active-low reset
//  raw_bit      in   1       asynchronous raw entropy bit from the sampler
//  en           in   1       collection enable; 0 aborts the partial word
//  word_data    out  WORD_W  collected word; valid when word_valid=1
//  word_valid   out  1       output word available
//  word_ready   in   1       consumer accepts word_data when word_valid=1
//  health_fail  out  1       sticky repetition-count failure
// BEHAVIOUR
//  Reset values: word_data=0, word_valid=0, health_fail=0. Internal state: shift reg, bit count,
//   pair flag and run counter all 0. FSM=IDLE.
//  Sync: raw_bit goes through a 2-flop synchroniser. The sample s is the second flop.
//   One sample is taken per clk while the FSM is in COLLECT.
//  FSM states: IDLE, COLLECT, FAIL.
//   IDLE -> COLLECT when en=1. COLLECT -> IDLE when en=0. Any state -> FAIL on health trip.
//   FAIL is left only by rst_n.
//  Leaving COLLECT for IDLE clears the shift reg, bit count, pair flag and run counter.
//   A pending output word is kept until it is handshaken.
//  Health test (COLLECT only, on raw samples, before debiasing):
//   - run counter resets to 1 when s differs from the previous sample, otherwise increments.
//   - run counter saturates at REP_LIMIT.
//   - when it reaches REP_LIMIT: health_fail=1 on the next cycle and the FSM enters FAIL.
//  FAIL: word_valid forced to 0, the pending word is discarded, no further samples are taken,
//   health_fail held at 1.
//  Debias (VN_EN=1): samples are paired in order (first, second).
//   - 01 -> accept 0; 10 -> accept 1; 00 or 11 -> discard.
//   - the pair flag toggles on every sample.
//  Debias (VN_EN=0): every sample is accepted.
//  Packing: each accepted bit does shreg <= {shreg[WORD_W-2:0], bit}, so the first accepted bit
//   ends up in the MSB. The bit count wraps from WORD_W-1 to 0.
//  Word completion, on the cycle that takes the WORD_W-th bit:
//   - output slot empty: word_data <= completed word, word_valid=1 on the next cycle.
//   - output slot full: the completed word waits in shreg. Further accepted bits are
//     dropped (not counted) until the slot frees.
//   - word_valid & word_ready in the same cycle as completion: the new word loads and
//     word_valid stays 1 (back-to-back, no bubble).
//   - a word waiting in shreg moves to the output on the handshake cycle.
//  Handshake: word_data is stable while word_valid=1 & word_ready=0. Transfer happens when both
//   are 1. word_valid deasserts next cycle unless a new word loads.
//  Minimum latency: raw_bit edge to sample = 2 clk. Last accepted bit to word_valid = 1 clk.
//  rst_n asserted mid-word: all state returns to reset values immediately. The partial word is lost.
// STRUCTURE
//  trng_pkg: WORD_W/REP_LIMIT defaults and the FSM state encoding (IDLE/COLLECT/FAIL).
//   Also the run-counter width, $clog2(REP_LIMIT+1).
//  Sub-module sync_2ff (clk, rst_n, d, q) for raw_bit. Reusable for other asynchronous inputs.
//  Remainder is flat: FSM, health counter, debias pair logic, packer, output register.
// TESTING
//  1. VN_EN=0, en=1, raw_bit alternating starting 1, word_ready=1
//     -> word_data=32'hAAAA_AAAA valid 1 clk; health_fail stays 0.
//  2. VN_EN=1, raw_bit pairs repeating (1,0) for 64 samples
//     -> one word 32'hFFFF_FFFF. Pairs (0,1)x32 -> 32'h0000_0000.
//     Interleaved (1,1)/(0,0) pairs add no bits.
//  3. raw_bit held 1 for 32 consecutive samples (REP_LIMIT=32)
//     -> health_fail=1 and word_valid=0 from the next clk. Remains set after en toggles;
//     cleared only by rst_n.
//  4. word_ready=0 with two words completed -> first word held stable. Second word waits
//     in shreg and excess bits are dropped. On word_ready=1 the second word follows with no bubble.
//  5. rst_n pulsed low after 17 accepted bits
//     -> all outputs 0 asynchronously. The next word contains only post-reset bits.
//  6. en dropped after 10 bits, then re-raised
//     -> partial word discarded; the next word_data equals exactly the next 32 accepted bits.

Source files
------------

// File: rtl/trng_pkg.sv
// trng_pkg: shared defaults and the FSM state encoding for the raw entropy
// collector (trng_collector).
//   WORD_W_DEF    default output word width, in accepted bits
//   REP_LIMIT_DEF default repetition-count limit for the health test
//   state_t       collector FSM states
//   run_w()       width needed to hold a run counter that saturates at a limit
package trng_pkg;

    localparam int WORD_W_DEF    = 32;
    localparam int REP_LIMIT_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FAIL    = 2'd2
    } state_t;

    // The run counter must be able to hold REP_LIMIT itself.
    function automatic int run_w(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/trng_collector_sync.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs.
//   clk    destination clock
//   rst_n  asynchronous active-low reset, clears both flops
//   d      asynchronous input
//   q      synchronised output (second flop)
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/trng_collector.sv
// trng_collector: receive end of the raw entropy path. Synchronises the raw
// ring-oscillator bit, runs a repetition-count health test on the raw samples,
// optionally von Neumann debiases, and packs accepted bits MSB-first into
// WORD_W-bit words offered on a valid/ready handshake.
//   clk          system clock; one sample per clk while collecting
//   rst_n        asynchronous active-low reset
//   raw_bit      asynchronous raw entropy bit
//   en           collection enable; dropping it aborts the partial word
//   word_data    collected word, valid while word_valid=1
//   word_valid   output word available
//   word_ready   consumer accepts word_data when word_valid=1
//   health_fail  sticky repetition-count failure; output withheld once set
module trng_collector
    import trng_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter bit VN_EN     = 1'b1,
    parameter int REP_LIMIT = REP_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              raw_bit,
    input  logic              en,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              health_fail
);

    localparam int RUN_W = run_w(REP_LIMIT);
    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [RUN_W-1:0] LIMIT_V = RUN_W'(REP_LIMIT);
    localparam logic [CNT_W-1:0] LAST_V  = CNT_W'(WORD_W - 1);

    state_t            state, state_nxt;
    logic              s;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              pair, first;
    logic              prev;
    logic [RUN_W-1:0]  run, run_inc;
    logic              held;         // completed word parked in shreg

    logic              take, clear, trip, hs;
    logic              acc_bit, abit;
    logic              complete, load_new, load_held, load_word;
    logic [WORD_W-1:0] word_next, word_in;

    sync_2ff #(.W(1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_bit),
        .q     (s)
    );

    always_comb begin
        take  = (state == ST_COLLECT) && en;
        clear = (state == ST_COLLECT) && !en;
        hs    = word_valid && word_ready;

        // Repetition count on raw samples; run==0 means no previous sample yet.
        if (run == '0 || s != prev) run_inc = RUN_W'(1);
        else if (run == LIMIT_V)    run_inc = run;
        else                        run_inc = run + RUN_W'(1);
        trip = take && (run_inc == LIMIT_V);

        // Debias: second sample of a differing pair yields the first sample.
        if (VN_EN) begin
            acc_bit = take && pair && (first != s);
            abit    = first;
        end else begin
            acc_bit = take;
            abit    = s;
        end

        word_next = {shreg[WORD_W-2:0], abit};
        complete  = acc_bit && !held && (cnt == LAST_V);
        load_new  = complete && (!word_valid || word_ready);
        load_held = held && hs && !clear;
        load_word = load_new || load_held;
        word_in   = held ? shreg : word_next;

        state_nxt = state;
        case (state)
            ST_IDLE:    if (en) state_nxt = ST_COLLECT;
            ST_COLLECT: begin
                if (trip)     state_nxt = ST_FAIL;
                else if (!en) state_nxt = ST_IDLE;
            end
            ST_FAIL:    state_nxt = ST_FAIL;
            default:    state_nxt = ST_FAIL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            cnt         <= '0;
            pair        <= 1'b0;
            first       <= 1'b0;
            prev        <= 1'b0;
            run         <= '0;
            held        <= 1'b0;
            word_data   <= '0;
            word_valid  <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            state <= state_nxt;
            if (trip || state == ST_FAIL) begin
                // Fault is sticky: discard everything pending, take no samples.
                health_fail <= 1'b1;
                word_valid  <= 1'b0;
                word_data   <= '0;
                held        <= 1'b0;
            end else begin
                if (clear) begin
                    shreg <= '0;
                    cnt   <= '0;
                    pair  <= 1'b0;
                    prev  <= 1'b0;
                    run   <= '0;
                    held  <= 1'b0;
                end else begin
                    if (take) begin
                        prev <= s;
                        run  <= run_inc;
                        pair <= ~pair;
                        if (!pair) first <= s;
                        // While a word is parked, accepted bits are dropped.
                        if (acc_bit && !held) begin
                            shreg <= word_next;
                            cnt   <= complete ? '0 : cnt + CNT_W'(1);
                        end
                    end
                    if (load_held)                 held <= 1'b0;
                    else if (complete && !load_new) held <= 1'b1;
                end
                if (load_word) begin
                    word_data  <= word_in;
                    word_valid <= 1'b1;
                end else if (hs) begin
                    word_valid <= 1'b0;
                end
            end
        end
    end

endmodule
